// File: rtl/au_pkg.sv
// -----------------------------------------------------------------------------
// au_pkg
// Shared definitions for the add/subtract accumulator family.
//   au_state_e  : burst FSM encoding (IDLE, ACC, HOLD)
//   au_max_sgn  : largest 2's-complement value of a given width (0 then ones)
//   au_min_sgn  : smallest 2's-complement value of a given width (1 then zeros)
// The range helpers return 64-bit values, so they cover widths of 1 to 64.
// -----------------------------------------------------------------------------
package au_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no beats yet, accumulator/sticky/counter are zero
        ACC  = 2'd1,  // burst in progress
        HOLD = 2'd2   // result presented, waiting for downstream
    } au_state_e;

    function automatic longint au_max_sgn(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint au_min_sgn(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/AU_addsub_v.sv
// -----------------------------------------------------------------------------
// AU_addsub_v
// Combinational signed adder/subtractor with overflow detection.
//   add_sub = 0 : s = a + b + ci
//   add_sub = 1 : s = a - b - ci   (ci acts as borrow-in)
//   v           : the exact result does not fit in WIDTH signed bits
// Parameters
//   WIDTH : operand/result width
//   ARCH  : 0 behavioural (range check), 1 bit-level ripple, 2 vector add with
//           sign-based overflow. All three produce identical s and v.
// Ports
//   a, b    in  WIDTH  signed operands
//   ci      in  1      carry-in / borrow-in
//   add_sub in  1      operation select
//   s       out WIDTH  result (wrapped)
//   v       out 1      signed overflow
// -----------------------------------------------------------------------------
module AU_addsub_v
    import au_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ARCH  = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             add_sub,
    output logic [WIDTH-1:0] s,
    output logic             v
);

    generate
        if (ARCH == 0) begin : g_behav
            // Two guard bits hold the exact result of a +/- b +/- ci.
            localparam logic signed [WIDTH+1:0] MAX_EXT = (WIDTH+2)'(au_max_sgn(WIDTH));
            localparam logic signed [WIDTH+1:0] MIN_EXT = (WIDTH+2)'(au_min_sgn(WIDTH));

            logic signed [WIDTH+1:0] a_ext;
            logic signed [WIDTH+1:0] b_ext;
            logic signed [WIDTH+1:0] c_ext;
            logic signed [WIDTH+1:0] r_ext;

            assign a_ext = (WIDTH+2)'(signed'(a));
            assign b_ext = (WIDTH+2)'(signed'(b));
            assign c_ext = (WIDTH+2)'(signed'({1'b0, ci}));
            assign r_ext = add_sub ? (a_ext - b_ext - c_ext) : (a_ext + b_ext + c_ext);
            assign s     = r_ext[WIDTH-1:0];
            assign v     = (r_ext > MAX_EXT) || (r_ext < MIN_EXT);
        end else if (ARCH == 1) begin : g_ripple
            // a - b - ci == a + ~b + (1 - ci), so subtract inverts b and ci.
            logic [WIDTH-1:0] b_eff;
            logic [WIDTH:0]   c;

            assign b_eff = b ^ {WIDTH{add_sub}};

            // NOTE: every signal written in always_comb is assigned on every
            // path; a path that skips an assignment would infer a latch.
            always_comb begin
                c    = '0;
                s    = '0;
                c[0] = ci ^ add_sub;
                for (int i = 0; i < WIDTH; i++) begin
                    s[i]   = a[i] ^ b_eff[i] ^ c[i];
                    c[i+1] = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
                end
            end

            // Carry into the sign bit disagrees with carry out of it.
            assign v = c[WIDTH] ^ c[WIDTH-1];
        end else begin : g_vector
            logic [WIDTH-1:0] b_eff;

            assign b_eff = b ^ {WIDTH{add_sub}};
            assign s     = a + b_eff + WIDTH'(ci ^ add_sub);
            // Same-sign operands producing a result of the other sign.
            assign v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end
    endgenerate

endmodule

// File: rtl/au_addsub_acc.sv
// -----------------------------------------------------------------------------
// au_addsub_acc
// Burst accumulator behind AU_addsub_v. Each accepted beat adds x (+ci) to or
// subtracts x (+ci) from a running accumulator; overflow either saturates or
// wraps the accumulator and sets a sticky flag. The beat marked last ends the
// burst and the final sum, sticky flag and beat count are held on the output
// handshake until taken.
// Parameters
//   WIDTH     : data/accumulator width (>= 1)
//   ARCH      : adder architecture passed to AU_addsub_v (0..2)
//   SAT       : 1 saturate on overflow, 0 wrap
//   CNT_WIDTH : beat counter width (>= 1), counter saturates at all-ones
// Ports
//   clk        in  1          rising-edge clock
//   rst        in  1          synchronous active-high reset
//   in_valid   in  1          beat valid
//   in_ready   out 1          beat can be accepted (IDLE or ACC)
//   x          in  WIDTH      signed operand
//   ci         in  1          carry-in / borrow-in
//   add_sub    in  1          0 add, 1 subtract
//   clr        in  1          treat accumulator as 0 for this beat
//   last       in  1          beat ends the burst
//   out_valid  out 1          result valid (HOLD)
//   out_ready  in  1          downstream takes the result
//   sum        out WIDTH      final accumulator value
//   ovf        out 1          any beat of the burst overflowed
//   cnt        out CNT_WIDTH  beats in the burst
// -----------------------------------------------------------------------------
module au_addsub_acc
    import au_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ARCH      = 0,
    parameter int SAT       = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic                 ci,
    input  logic                 add_sub,
    input  logic                 clr,
    input  logic                 last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     sum,
    output logic                 ovf,
    output logic [CNT_WIDTH-1:0] cnt
);

    generate
        if (WIDTH < 1 || ARCH < 0 || ARCH > 2 || !(SAT == 0 || SAT == 1) || CNT_WIDTH < 1)
        begin : g_param_check
            $fatal(1, "au_addsub_acc: illegal parameter set (WIDTH>=1, ARCH 0..2, SAT 0/1, CNT_WIDTH>=1)");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_SGN = WIDTH'(au_max_sgn(WIDTH));
    localparam logic [WIDTH-1:0] MIN_SGN = WIDTH'(au_min_sgn(WIDTH));

    au_state_e            state;
    au_state_e            state_next;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     acc_next;
    logic [WIDTH-1:0]     a_op;
    logic [WIDTH-1:0]     s_raw;
    logic                 v_raw;
    logic                 sticky;
    logic                 sticky_next;
    logic [CNT_WIDTH-1:0] beats;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 accept;
    logic                 restart;

    // Handshake flags come from state only, so out_ready never reaches in_ready.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    // First beat of a burst and clr both start from an empty accumulator.
    assign restart = (state == IDLE) || clr;
    assign a_op    = restart ? '0 : acc;

    AU_addsub_v #(
        .WIDTH (WIDTH),
        .ARCH  (ARCH)
    ) u_addsub (
        .a       (a_op),
        .b       (x),
        .ci      (ci),
        .add_sub (add_sub),
        .s       (s_raw),
        .v       (v_raw)
    );

    always_comb begin
        acc_next = s_raw;
        // A wrapped result with a clear sign bit came from a negative overflow.
        if (SAT == 1 && v_raw) begin
            acc_next = s_raw[WIDTH-1] ? MAX_SGN : MIN_SGN;
        end
        sticky_next = (restart ? 1'b0 : sticky) | v_raw;
        cnt_base    = restart ? '0 : beats;
        cnt_next    = (&cnt_base) ? cnt_base : cnt_base + CNT_WIDTH'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACC: if (accept) state_next = last ? HOLD : ACC;
            HOLD:      if (out_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            sticky <= 1'b0;
            beats  <= '0;
            sum    <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                acc    <= acc_next;
                sticky <= sticky_next;
                beats  <= cnt_next;
                if (last) begin
                    sum <= acc_next;
                    ovf <= sticky_next;
                    cnt <= cnt_next;
                end
            end else if (out_valid && out_ready) begin
                // Back to IDLE with an empty burst.
                acc    <= '0;
                sticky <= 1'b0;
                beats  <= '0;
            end
        end
    end

endmodule

// File: doc/au_addsub_acc.md
# au_addsub_acc

Burst accumulator stage that sits directly downstream of `AU_addsub_v` and consumes its sum/difference and overflow flag. Operand beats arrive over a valid/ready handshake and are added to, or subtracted from, a running accumulator. The block can saturate the accumulator on 2's-complement overflow and keeps a sticky overflow flag for the burst. At the end of each burst it presents one registered result with its own valid/ready handshake.

## Interface
- `WIDTH`, 8: data and accumulator word length; must be ≥ 1.
- `ARCH`, 0: passed unchanged to the `AU_addsub_v` instance; legal range 0 to 2.
- `SAT`, 1: overflow handling. 1 saturates the accumulator; 0 wraps it.
- `CNT_WIDTH`, 8: width of the beat counter; must be ≥ 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `x`  in  WIDTH  signed operand.
- `ci`  in  1  carry-in (add) or borrow-in (subtract) for this beat.
- `add_sub`  in  1  0: acc + x + ci; 1: acc − x − ci.
- `clr`  in  1  treat the accumulator as 0 before applying this beat.
- `last`  in  1  this beat ends the burst.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  WIDTH  final accumulator value of the burst.
- `ovf`  out  1  sticky overflow flag: any beat in the burst overflowed.
- `cnt`  out  CNT_WIDTH  number of beats in the burst, saturating at all-ones.

## Operation
- States:
  - IDLE: no beats yet; accumulator, sticky flag and counter are 0.
  - ACC: burst in progress.
  - HOLD: result is being presented.
- A beat is accepted on a rising edge where `in_valid && in_ready`. `in_ready` is 1 in IDLE and ACC and 0 in HOLD. It is decoded from state only, with no combinational path from `out_ready`.
- Per accepted beat, the instance inputs are:
  - `a` = (IDLE or `clr`) ? 0 : acc.
  - `b` = `x`.
  - `ci` and `add_sub` are passed through.
- Next accumulator value:
  - If `v` = 1 and `SAT` = 1: `s[WIDTH-1]` ? MaxSgn (0 followed by ones) : MinSgn (1 followed by zeros).
  - Otherwise: `s`.
- Sticky flag: (IDLE or `clr` ? 0 : sticky) | `v`. Saturation does not clear it.
- Beat counter: (IDLE or `clr` ? 0 : cnt) + 1, saturating at 2^CNT_WIDTH − 1.
- State transitions:
  - IDLE or ACC with an accepted beat and `last` = 0 → ACC.
  - IDLE or ACC with an accepted beat and `last` = 1 → HOLD. `sum`, `ovf` and `cnt` load the updated values.
  - HOLD with `out_ready` = 1 → IDLE.
  - No accepted beat → state is held.
- In HOLD, `sum`, `ovf` and `cnt` remain stable until the handshake completes.
- `clr` on the first beat of a burst has no additional effect.

## Timing
- Reset (`rst` = 1 at an edge) forces: state IDLE, accumulator 0, `sum` 0, `ovf` 0, `cnt` 0, `out_valid` 0, `in_ready` 1. Reset overrides any handshake in the same cycle.
- Reset mid-burst or in HOLD discards the partial or pending result; no output is emitted.
- Latency: when the last beat is accepted at edge k, `out_valid` = 1 from edge k to edge k+1 onward.
- After the output handshake at edge m, `in_ready` = 1 after edge m. This gives a minimum one-cycle input bubble per burst.
- Throughput in ACC is one beat per cycle.
- Behaviour while `out_valid` = 0 and `out_ready` = 1: no effect.
- `x`, `ci`, `add_sub`, `clr` and `last` are ignored when no beat is accepted.

## Structure
- Shared package `au_pkg` holds:
  - the state encoding constants IDLE, ACC, HOLD;
  - functions `au_max_sgn(WIDTH)` and `au_min_sgn(WIDTH)`, which the `AU_addsub_v` behavioural model also uses for its overflow range check.
- There is one sub-module: a combinational `AU_addsub_v` instance with `WIDTH` and `ARCH` passed through. The accumulator, saturation mux, counter and FSM are local to this block.
- A parameter legality check (`WIDTH` ≥ 1, `ARCH` 0 to 2, `SAT` 0 or 1, `CNT_WIDTH` ≥ 1) aborts simulation on violation.

## Test plan
1. **Reset:** hold `rst` high for 2 cycles with `in_valid` = 1 → `in_ready` = 1, `out_valid` = 0, `sum` = 0, `ovf` = 0, `cnt` = 0. No beat is counted.
2. **Basic burst** (`WIDTH` = 8): +10; +20 with `ci` = 1; −5 with `last` → `out_valid` one cycle after the last accept, `sum` = 0x1A, `ovf` = 0, `cnt` = 3.
3. **Positive overflow:** +100, +100 `last` → `SAT` = 1: `sum` = 0x7F, `ovf` = 1. `SAT` = 0: `sum` = 0xC8, `ovf` = 1.
4. **Negative overflow then recovery:** −100, −100 with `ci` = 1, +100 `last` (`SAT` = 1) → `sum` = 0xE4 (−28), `ovf` = 1, `cnt` = 3.
5. **Backpressure:** `out_ready` = 0 for 5 cycles in HOLD with `in_valid` = 1 → `in_ready` = 0 and outputs stable. After `out_ready` = 1, the next burst +3 `last` gives `sum` = 0x03, `ovf` = 0, `cnt` = 1.
6. **`clr`, counter and reset corner cases:**
   - +50, then +3 with `clr` and `last` → `sum` = 0x03, `cnt` = 1.
   - `CNT_WIDTH` = 2, 5 beats → `cnt` = 3.
   - `rst` in HOLD → `out_valid` = 0 next cycle and the result is lost.
